axis_restoring_divider: RTL and testbench

//   Unsigned radix-2 restoring divider with AXI4-Stream slave inputs (dividend, divisor) and an
//   AXI4-Stream master output carrying {quotient, remainder}. It is the responder side of the

---
 rtl/axis_restoring_divider.sv | 125 ++++++++++++
 tb/tb_axis_restoring_divider.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_restoring_divider.sv
// Unsigned radix-2 restoring divider, AXI4-Stream operands in, {quotient, remainder} out.
// Optional divide-by-zero flag on m_axis_dout_tuser when AXIS_DIV_TUSER_EN is defined.
module axis_restoring_divider #(
    parameter int DATA_SIZE = 64
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic                     s_axis_dividend_tvalid,
    output logic                     s_axis_dividend_tready,
    input  logic [DATA_SIZE-1:0]     s_axis_dividend_tdata,
    input  logic                     s_axis_divisor_tvalid,
    output logic                     s_axis_divisor_tready,
    input  logic [DATA_SIZE-1:0]     s_axis_divisor_tdata,
    output logic                     m_axis_dout_tvalid,
    input  logic                     m_axis_dout_tready,
    output logic [2*DATA_SIZE-1:0]   m_axis_dout_tdata
`ifdef AXIS_DIV_TUSER_EN
    ,
    output logic                     m_axis_dout_tuser
`endif
);

    localparam int CNT_W = $clog2(DATA_SIZE) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_n;

    logic [DATA_SIZE-1:0] quot_q;
    logic [DATA_SIZE-1:0] div_q;
    logic [DATA_SIZE:0]   rem_q;
    logic [DATA_SIZE:0]   rem_n;
    logic [DATA_SIZE+1:0] shifted;
    logic [DATA_SIZE+1:0] diff;
    logic [CNT_W-1:0]     cnt_q;
    logic                 idle;
    logic                 accept;
    logic                 last;
    logic                 neg;

    assign idle   = (state == IDLE);
    assign accept = idle & s_axis_dividend_tvalid & s_axis_divisor_tvalid;
    assign last   = (cnt_q == LAST);

    // Gated by reset so the ready outputs read 0 while reset is held.
    assign s_axis_dividend_tready = idle & i_reset_n;
    assign s_axis_divisor_tready  = idle & i_reset_n;

    assign m_axis_dout_tvalid = (state == DONE);
    assign m_axis_dout_tdata  = {quot_q, rem_q[DATA_SIZE-1:0]};

    // quot_q doubles as the dividend shifter: its MSB feeds the remainder.
    assign shifted = {rem_q, quot_q[DATA_SIZE-1]};
    assign diff    = shifted - {2'b00, div_q};
    assign neg     = diff[DATA_SIZE+1];
    assign rem_n   = neg ? shifted[DATA_SIZE:0] : diff[DATA_SIZE:0];

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (m_axis_dout_tready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            quot_q <= '0;
            div_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            quot_q <= s_axis_dividend_tdata;
            div_q  <= s_axis_divisor_tdata;
            rem_q  <= '0;
            cnt_q  <= '0;
        end else if (state == CALC) begin
            quot_q <= {quot_q[DATA_SIZE-2:0], ~neg};
            rem_q  <= rem_n;
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

`ifdef AXIS_DIV_TUSER_EN
    logic zero_q;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            zero_q <= 1'b0;
        end else if (accept) begin
            zero_q <= (s_axis_divisor_tdata == '0);
        end
    end

    assign m_axis_dout_tuser = zero_q;
`endif

endmodule

// File: tb/tb_axis_restoring_divider.sv
// Directed and randomized bench for axis_restoring_divider (DATA_SIZE = 64),
// checked against plain integer division.
module tb_axis_restoring_divider;

    localparam int W = 64;
    localparam int LAT = W + 1;

    logic           clk;
    logic           rst_n;
    logic           dvd_valid;
    logic           dvd_ready;
    logic [W-1:0]   dvd_data;
    logic           dvs_valid;
    logic           dvs_ready;
    logic [W-1:0]   dvs_data;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_data;
`ifdef AXIS_DIV_TUSER_EN
    logic           out_user;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int hs_cyc = 0;

    axis_restoring_divider #(.DATA_SIZE(W)) dut (
        .i_clock                (clk),
        .i_reset_n              (rst_n),
        .s_axis_dividend_tvalid (dvd_valid),
        .s_axis_dividend_tready (dvd_ready),
        .s_axis_dividend_tdata  (dvd_data),
        .s_axis_divisor_tvalid  (dvs_valid),
        .s_axis_divisor_tready  (dvs_ready),
        .s_axis_divisor_tdata   (dvs_data),
        .m_axis_dout_tvalid     (out_valid),
        .m_axis_dout_tready     (out_ready),
        .m_axis_dout_tdata      (out_data)
`ifdef AXIS_DIV_TUSER_EN
        ,
        .m_axis_dout_tuser      (out_user)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [2*W-1:0] obs,
                         input logic [2*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (b == 0) begin
            q = '1;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok;
        ok = 0;
        dvd_data = a;
        dvs_data = b;
        dvd_valid = 1'b1;
        dvs_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dvd_ready && dvs_ready) begin
                ok = 1;
                break;
            end
        end
        check("accept_timeout", 128'(ok), 128'(1));
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
    endtask

    task automatic recv(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall);
        bit got;
        logic [2*W-1:0] exp;
        exp = model(a, b);
        got = 0;
        out_ready = (stall == 0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1;
                break;
            end
        end
        check("result_timeout", 128'(got), 128'(1));
        if (!got) return;
        check("latency", 128'(cyc - acc_cyc), 128'(LAT));
        check("quotient", 128'(out_data[2*W-1:W]), 128'(exp[2*W-1:W]));
        check("remainder", 128'(out_data[W-1:0]), 128'(exp[W-1:0]));
`ifdef AXIS_DIV_TUSER_EN
        check("tuser", 128'(out_user), 128'(b == 0));
`endif
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("hold_valid", 128'(out_valid), 128'(1));
            check("hold_data", out_data, exp);
        end
        out_ready = 1'b1;
        hs_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] ones;
        bit quiet;
        ones = '1;
        rst_n = 1'b0;
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        dvd_data = '0;
        dvs_data = '0;
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_dvd_ready", 128'(dvd_ready), 128'(0));
        check("rst_dvs_ready", 128'(dvs_ready), 128'(0));
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_data", out_data, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 128'(dvd_ready & dvs_ready), 128'(1));
        @(posedge clk);
        #1;

        send(10, 2);
        recv(10, 2, 0);

        send(7, 3);
        dvd_data = ones;
        dvs_data = 1;
        dvd_valid = 1'b1;
        dvs_valid = 1'b1;
        recv(7, 3, 0);
        send(ones, 1);
        check("b2b_accept", 128'(acc_cyc - hs_cyc), 128'(1));
        recv(ones, 1, 0);

        send(123, 0);
        recv(123, 0, 0);

        dvd_valid = 1'b1;
        dvs_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dvd_data = W'(1000 + i * 17);
            @(negedge clk);
            check("lone_no_accept", 128'(dvd_ready), 128'(1));
            @(posedge clk);
            #1;
        end
        send(1068, 11);
        recv(1068, 11, 0);

        send(100, 7);
        recv(100, 7, 20);
        @(negedge clk);
        check("ready_after_bp", 128'(dvd_ready & dvs_ready), 128'(1));
        @(posedge clk);
        #1;

        send(3, 9);
        recv(3, 9, 0);
        send(77, 77);
        recv(77, 77, 0);
        send(ones, ones);
        recv(ones, ones, 0);

        send(50, 5);
        repeat (29) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_valid", 128'(out_valid), 128'(0));
        check("abort_dvd_ready", 128'(dvd_ready), 128'(0));
        check("abort_dvs_ready", 128'(dvs_ready), 128'(0));
        check("abort_data", out_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 128'(dvd_ready & dvs_ready), 128'(1));
        quiet = 1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) quiet = 0;
        end
        check("no_replay", 128'(quiet), 128'(1));
        @(posedge clk);
        #1;
        send(9, 4);
        recv(9, 4, 0);

        for (int n = 0; n < 10; n++) begin
            a = {$urandom, $urandom} >> $urandom_range(0, 20);
            b = {$urandom, $urandom} >> $urandom_range(0, 63);
            if (n == 4) b = 0;
            send(a, b);
            recv(a, b, (n % 3 == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
